// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter that owns the 16:1 mux.
package mux_rr_arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef logic [SEL_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index arithmetic wraps naturally at N_REQ because N_REQ == 2**SEL_W.
    function automatic idx_t rotate_index(input idx_t ptr, input idx_t offset);
        return idx_t'(ptr + offset);
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_pick
    import mux_rr_arbiter_pkg::*;
(
    input  req_t req,
    input  idx_t ptr,
    output idx_t winner,
    output logic any_req
);

    req_t rotated;
    idx_t offset;

    always_comb begin
        // NOTE: every variable gets a default before the loops so no latch is inferred.
        rotated = '0;
        offset  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rotated[k] = req[rotate_index(ptr, idx_t'(k))];
        end
        // Scanning from the top down leaves the lowest set offset as the winner.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) offset = idx_t'(k);
        end
    end

    assign winner  = rotate_index(ptr, offset);
    assign any_req = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner sequencer for the shared 16:1 mux: grants, hold limit, guard gap.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic [SEL_W-1:0] sel,
    output logic             mux_en_n,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             timeout,
    output logic [7:0]       grant_cnt
);

    state_t     state, state_d;
    idx_t       ptr, ptr_d;
    logic [7:0] hold_cnt, hold_cnt_d;
    idx_t       sel_d;
    req_t       grant_d;
    logic       mux_en_n_d, grant_valid_d, timeout_d;
    logic [7:0] grant_cnt_d;

    idx_t winner;
    logic any_req;

    rr_priority_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    logic at_limit, owner_req, end_own;
    assign at_limit  = (hold_cnt == 8'(MAX_HOLD));
    assign owner_req = req[sel];
    assign end_own   = release_i | ~owner_req | at_limit;

    // NOTE: reset is synchronous and covers every flop, so a mid-OWN reset drops the grant on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            sel         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            mux_en_n    <= 1'b1;
            timeout     <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state       <= state_d;
            ptr         <= ptr_d;
            hold_cnt    <= hold_cnt_d;
            sel         <= sel_d;
            grant       <= grant_d;
            grant_valid <= grant_valid_d;
            mux_en_n    <= mux_en_n_d;
            timeout     <= timeout_d;
            grant_cnt   <= grant_cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, GAP: state_d = any_req ? OWN : IDLE;
            OWN:       if (end_own) state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and bookkeeping counters.
    always_comb begin
        ptr_d         = ptr;
        hold_cnt_d    = hold_cnt;
        sel_d         = sel;
        grant_d       = grant;
        grant_valid_d = grant_valid;
        mux_en_n_d    = mux_en_n;
        timeout_d     = 1'b0;
        grant_cnt_d   = grant_cnt;

        if (state != OWN && state_d == OWN) begin
            sel_d         = winner;
            grant_d       = req_t'(1) << winner;
            grant_valid_d = 1'b1;
            mux_en_n_d    = 1'b0;
            hold_cnt_d    = 8'd1;
            ptr_d         = rotate_index(winner, idx_t'(1));
            grant_cnt_d   = grant_cnt + 8'd1;
        end else if (state == OWN && end_own) begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            mux_en_n_d    = 1'b1;
            hold_cnt_d    = '0;
            // Only a pure hold-limit expiry counts as a timeout.
            timeout_d     = at_limit & ~release_i & owner_req;
        end else if (state == OWN) begin
            hold_cnt_d    = hold_cnt + 8'd1;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the team's 16:1 bit mux (two 8:1 halves, active-low enable) among 16 requesters.
- Grants one requester at a time. Drives the 4-bit mux select and the active-low mux enable.
- Bounds each ownership with a hold-cycle limit and inserts a one-cycle guard gap between owners.
- Sits between the requesting channel agents and the mux datapath.

Parameters:
- N_REQ, 16, number of requesters; fixed to mux width, must equal 2**SEL_W.
- SEL_W, 4, select width.
- MAX_HOLD, 8, maximum cycles one owner keeps the mux; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector, bit i = requester i; level-sensitive.
- release_i  input  1  current owner finished; sampled only in OWN.
- sel  output  4  mux select, registered; valid while grant_valid = 1.
- mux_en_n  output  1  active-low mux enable, registered; 0 only in OWN.
- grant  output  16  one-hot grant, registered; zero outside OWN.
- grant_valid  output  1  high in OWN.
- timeout  output  1  one-cycle pulse when ownership ends by hold limit alone.
- grant_cnt  output  8  number of grants issued since reset, wraps at 255 -> 0.

Behaviour:
- Reset (rst = 1 at an edge) gives:
  - state = IDLE, sel = 0, mux_en_n = 1, grant = 0, grant_valid = 0, timeout = 0, grant_cnt = 0.
  - ptr = 0, hold_cnt = 0.
  - Reset wins over everything, including mid-OWN; the grant drops on that edge.
- States are IDLE, OWN and GAP.
- Arbitration (combinational, from req and ptr):
  - Winner = first set bit of req searching index ptr, ptr+1, ... 15, 0, ... ptr-1, wrapping mod 16.
  - After reset, index 0 has the highest priority.
- IDLE:
  - If req != 0 at an edge, on that edge: sel = winner, grant = 1 << winner, grant_valid = 1, mux_en_n = 0, hold_cnt = 1, ptr = (winner + 1) mod 16, grant_cnt increments, state = OWN.
  - Latency from req rising to grant visible is one edge.
  - If req == 0, stay in IDLE.
- OWN:
  - End condition E = release_i OR (req[sel] == 0) OR (hold_cnt == MAX_HOLD).
  - If E is false: hold_cnt increments and the outputs hold.
  - If E is true, at the next edge: state = GAP, grant = 0, grant_valid = 0, mux_en_n = 1, sel holds its last value.
  - timeout = 1 for that GAP cycle only if hold_cnt == MAX_HOLD AND release_i == 0 AND req[sel] == 1.
- GAP lasts exactly one cycle:
  - If req != 0, at the next edge issue a new grant exactly as from IDLE, using the updated ptr.
  - Otherwise go to IDLE.
  - timeout returns to 0.
- Fairness:
  - A requester that just owned the mux has the lowest priority in the next arbitration.
  - A requester holding req continuously waits at most 15 × (MAX_HOLD + 1) cycles.
- Simultaneous events:
  - release_i together with the timeout condition counts as release, so timeout = 0.
  - req changes in GAP are sampled at the GAP-exit edge.
- release_i outside OWN is ignored.
- grant is always one-hot or zero. sel always equals the index of the set grant bit while grant_valid = 1.
- With MAX_HOLD = 1, every ownership is exactly one cycle, followed by GAP.

Decomposition:
- Shared package holds:
  - state enum (IDLE, OWN, GAP).
  - N_REQ/SEL_W constants.
  - a function `rotate_index(ptr, offset)` for mod-16 wrap.
- One natural sub-module, rr_priority_pick: combinational. Takes req and ptr; returns the winner index plus an any_req flag. It implements the rotate, priority-encode and un-rotate steps.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Reset mid-ownership: grant to req bit 5, assert rst for 1 cycle -> next cycle grant = 0, mux_en_n = 1, grant_cnt = 0. After rst drops, req = 0x0021 grants index 0 first.
- Round-robin order: req = 0x8421 held, all owners release after 2 cycles -> grant order 0, 5, 10, 15, 0. Each owner spans 2 cycles followed by a 1-cycle gap. grant_cnt = 5.
- Hold limit: MAX_HOLD = 8, req = 0x0008 held, release_i = 0 -> grant_valid high exactly 8 cycles. timeout pulses once in the GAP cycle. The same requester is re-granted after GAP.
- Release collides with limit: release_i = 1 on the cycle hold_cnt = 8 -> ownership ends, timeout stays 0.
- Requester drop: owner index 3 deasserts req[3] on its 2nd owned cycle, req = 0x0108 -> GAP next cycle, then grant index 8 with sel = 8.
- Wrap/idle: only req[15] pulses, then req = 0 -> grant index 15, ptr wraps to 0, FSM returns to IDLE with mux_en_n = 1. grant_cnt wraps from 255 to 0 after 256 grants.
